dw_mult_mx_pipe: RTL
====================

# dw_mult_mx_pipe

Pipelined multi-mode partitionable multiplier with valid/ready flow control. Each accepted operand pair is multiplied as one full-width product (simplex), two independent sub-products (duplex, split at `p1_width`), or four equal sub-products (quad), signed or unsigned. The result emerges `stages` cycles later, tagged with its mode. It is the registered, streaming successor of the combinational duplex multiplier, for datapaths that time-share one multiplier array across packed narrow operands.

## Interface
- `width`, 16: operand width; ≥8 and a multiple of 4.
- `p1_width`, 8: duplex low-lane width; 2 to `width`-2.
- `stages`, 3: pipeline depth in register stages; 1 to 4.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand pair presented.
- `in_ready`  out  1  block can accept this cycle.
- `a`  in  `width`  operand A.
- `b`  in  `width`  operand B.
- `tc`  in  1  1 = two's complement, 0 = unsigned; applies to every lane.
- `mode`  in  2  00 simplex, 01 duplex, 10 quad, 11 reserved (treated as simplex).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `product`  out  2*`width`  packed result.
- `out_mode`  out  2  `mode` of the operation in `product`; 11 is output as 00.

## Operation
- Transfer in: `in_valid & in_ready` at a rising edge. Transfer out: `out_valid & out_ready`.
- Simplex: `product` = `a` × `b`, full 2*`width` bits. The sign of each operand comes from bit `width`-1 when `tc`=1.
- Duplex: lane0 = `a[p1_width-1:0]` × `b[p1_width-1:0]` → `product[2*p1_width-1:0]`. Lane1 = `a[width-1:p1_width]` × `b[width-1:p1_width]` → `product[2*width-1:2*p1_width]`.
- Quad: q = `width`/4. Lane k (k=0..3) = `a[q*k +: q]` × `b[q*k +: q]` → `product[2q*k +: 2q]`.
- Each lane product is exact at 2× its lane width. With `tc`=1, each lane's top bit is its sign bit. No carry or sign crosses a lane boundary.
- Pipeline: per-stage valid bit `v[k]`, k = 0..`stages`-1. The last stage drives `out_valid`, `product` and `out_mode`. The product is computed combinationally before stage 0; later stages only move data, and synthesis may retime the logic.
- Stage advance, bubble-collapsing:
  - `adv[stages]` = `out_ready`.
  - Stage k loads from stage k-1 (stage 0 loads from the inputs) when `!v[k] | adv[k+1]`.
  - `v[k]` takes the upstream valid on a load, and is otherwise held.
- `in_ready` = `!rst & (!v[0] | adv[1])`. This is a combinational path from `out_ready`, which is permitted.
- A stage that is not loading holds its data. `product` and `out_mode` are stable while `out_valid & !out_ready`.
- `product` keeps its last value after a transfer out with no replacement. Its value is don't-care-free: there are no X outputs.
- Throughput is one operation per cycle with no backpressure. Order is strictly preserved, with no loss or duplication.

## Timing
- Reset:
  - While `rst`=1: `in_ready`=0.
  - After the first edge with `rst`=1: all `v[k]`=0, `out_valid`=0, `product`=0, `out_mode`=00, and all stage data are 0.
  - On the first cycle after `rst` drops: `in_ready`=1.
- Latency: an operation accepted at edge t gives `out_valid`=1 after edge t+`stages`-1 when no stall occurs. For `stages`=1, the result is visible in the cycle after acceptance.
- Reset mid-operation: all in-flight operations are discarded and never emerge. Input presented during `rst`=1 is not accepted.
- Full pipeline (all `v`=1) with `out_ready`=0: `in_ready`=0 and nothing moves.
- Full pipeline with `out_ready`=1: a transfer out and a transfer in occur on the same edge, and occupancy is unchanged.
- A bubble in stage k is filled the next edge even when `out_ready`=0.
- `mode` and `tc` are sampled only on a transfer in. Changing them between operations affects only the newly accepted one.

## Test plan
- Simplex unsigned (`width`=16, `p1_width`=8, `stages`=3): `a`=FFFF, `b`=FFFF, `tc`=0, `mode`=00 → 3 edges later `out_valid`=1, `product`=FFFE0001, `out_mode`=00.
- Simplex signed: `a`=FFFF, `b`=0002, `tc`=1 → `product`=FFFFFFFE. The same operands with `tc`=0 give 0001FFFE.
- Duplex signed: `a`=03FE, `b`=FD05, `tc`=1, `mode`=01 → `product`=FFF7FFF6 (lane1 3×−3, lane0 −2×5).
- Quad unsigned: `a`=FFFF, `b`=1234, `mode`=10 → `product`=0F1E2D3C. With `mode`=11, the same operands yield the simplex result 1233EDCC and `out_mode`=00.
- Backpressure: stream 6 back-to-back operations and hold `out_ready`=0 for 4 cycles after the first `out_valid`.
  - `in_ready` falls once 3 are buffered, and `product` is stable while stalled.
  - After release, all 6 results emerge in order, with no gaps and no duplicates.
- Reset mid-stream: assert `rst` for 1 cycle with 2 operations in flight → next cycle `out_valid`=0 and `product`=0. Neither operation ever emerges, and `in_ready`=1 the cycle after `rst` drops.

Source files
------------

// File: rtl/dw_mult_mx_pipe.sv
// Pipelined partitionable multiplier: simplex, duplex or quad lanes.
// Bubble-collapsing valid/ready pipeline with mode tag alongside data.
module dw_mult_mx_pipe #(
  parameter int width    = 16,
  parameter int p1_width = 8,
  parameter int stages   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     a,
  input  logic [width-1:0]     b,
  input  logic                 tc,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*width-1:0]   product,
  output logic [1:0]           out_mode
);

  localparam int W = width;
  localparam int P = p1_width;
  localparam int H = width - p1_width;
  localparam int Q = width / 4;
  localparam int S = stages;

  logic [2*W-1:0] sa, sb, ps;
  logic [2*P-1:0] d0a, d0b, pd0;
  logic [2*H-1:0] d1a, d1b, pd1;
  logic [2*W-1:0] pq;
  logic [2*W-1:0] res;
  logic [1:0]     mode_n;

  assign sa  = {{W{tc & a[W-1]}}, a};
  assign sb  = {{W{tc & b[W-1]}}, b};
  assign ps  = sa * sb;

  assign d0a = {{P{tc & a[P-1]}}, a[P-1:0]};
  assign d0b = {{P{tc & b[P-1]}}, b[P-1:0]};
  assign pd0 = d0a * d0b;
  assign d1a = {{H{tc & a[W-1]}}, a[W-1:P]};
  assign d1b = {{H{tc & b[W-1]}}, b[W-1:P]};
  assign pd1 = d1a * d1b;

  for (genvar k = 0; k < 4; k++) begin : g_q
    logic [2*Q-1:0] xa, xb;
    assign xa = {{Q{tc & a[Q*k+Q-1]}}, a[Q*k +: Q]};
    assign xb = {{Q{tc & b[Q*k+Q-1]}}, b[Q*k +: Q]};
    assign pq[2*Q*k +: 2*Q] = xa * xb;
  end

  // Reserved mode 11 runs as simplex and is tagged as such.
  always_comb begin
    res    = ps;
    mode_n = 2'b00;
    unique case (1'b1)
      (mode == 2'b01): begin
        res    = {pd1, pd0};
        mode_n = 2'b01;
      end
      (mode == 2'b10): begin
        res    = pq;
        mode_n = 2'b10;
      end
      default: begin
        res    = ps;
        mode_n = 2'b00;
      end
    endcase
  end

  logic [S-1:0]   v_q;
  logic [2*W-1:0] p_q [S];
  logic [1:0]     m_q [S];
  logic [S-1:0]   ld;
  logic [S-1:0]   up_v;
  logic [2*W-1:0] up_p [S];
  logic [1:0]     up_m [S];

  always_comb begin : c_adv
    logic nxt;
    nxt = out_ready;
    ld  = '0;
    for (int k = S - 1; k >= 0; k--) begin
      ld[k] = !v_q[k] | nxt;
      nxt   = ld[k];
    end
  end

  assign in_ready = !rst & ld[0];

  for (genvar k = 0; k < S; k++) begin : g_up
    if (k == 0) begin : g_first
      assign up_v[0] = in_valid & in_ready;
      assign up_p[0] = res;
      assign up_m[0] = mode_n;
    end else begin : g_rest
      assign up_v[k] = v_q[k-1];
      assign up_p[k] = p_q[k-1];
      assign up_m[k] = m_q[k-1];
    end
  end

  // Data only moves with a valid token so the output holds after drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < S; k++) begin
        p_q[k] <= '0;
        m_q[k] <= 2'b00;
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        if (ld[k]) begin
          v_q[k] <= up_v[k];
          if (up_v[k]) begin
            p_q[k] <= up_p[k];
            m_q[k] <= up_m[k];
          end
        end
      end
    end
  end

  assign out_valid = v_q[S-1];
  assign product   = p_q[S-1];
  assign out_mode  = m_q[S-1];

endmodule
